// File: rtl/cpu_controller_if.sv
// rtl/cpu_controller_if.sv - instruction/start inputs and datapath control strobes of cpu_controller
interface cpu_controller_if;
   logic        s;
   logic        load;
   logic [15:0] in;
   logic        write;
   logic        vsel;
   logic        loada;
   logic        loadb;
   logic        asel;
   logic        bsel;
   logic        loadc;
   logic        loads;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic [1:0]  shift;
   logic [1:0]  ALUop;
   logic [15:0] datapath_in;
   logic        w;
   logic        illegal;

   // master: the controller; slave: instruction source plus datapath
   modport master (
      input  s, load, in,
      output write, vsel, loada, loadb, asel, bsel, loadc, loads,
      output readnum, writenum, shift, ALUop, datapath_in, w, illegal
   );

   modport slave (
      output s, load, in,
      input  write, vsel, loada, loadb, asel, bsel, loadc, loads,
      input  readnum, writenum, shift, ALUop, datapath_in, w, illegal
   );
endinterface

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction register, decoder and Moore control FSM for the 16-bit datapath
module cpu_controller #(
   parameter logic [15:0] IR_RESET = 16'h0000
) (
   input  logic             clk,
   input  logic             reset,
   cpu_controller_if.master bus
);

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_DECODE,
      ST_WRITE_IMM,
      ST_GET_A,
      ST_GET_B,
      ST_EXEC,
      ST_WRITE_REG
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] ir;

   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] rn;
   logic [2:0] rd;
   logic [1:0] sh;
   logic [2:0] rm;

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign sh     = ir[4:3];
   assign rm     = ir[2:0];

   logic is_mov_imm;
   logic is_mov_reg;
   logic is_alu;
   logic is_mvn;
   logic is_cmp;

   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu     = (opcode == 3'b101);
   assign is_mvn     = is_alu && (op == 2'b11);
   assign is_cmp     = is_alu && (op == 2'b01);

   // load is honoured only while idle so a running instruction never sees its IR change
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_WAIT;
         ir    <= IR_RESET;
      end else begin
         state <= state_next;
         if (state == ST_WAIT && bus.load) begin
            ir <= bus.in;
         end
      end
   end

   assign bus.datapath_in = {{8{ir[7]}}, ir[7:0]};
   assign bus.shift       = (is_mov_reg || is_alu) ? sh : 2'b00;
   assign bus.ALUop       = is_alu ? op : 2'b00;
   assign bus.bsel        = 1'b0;

   logic       write;
   logic       vsel;
   logic       loada;
   logic       loadb;
   logic       asel;
   logic       loadc;
   logic       loads;
   logic       w;
   logic       illegal;
   logic [2:0] readnum;
   logic [2:0] writenum;

   always_comb begin
      state_next = state;
      write      = 1'b0;
      vsel       = 1'b0;
      loada      = 1'b0;
      loadb      = 1'b0;
      asel       = 1'b0;
      loadc      = 1'b0;
      loads      = 1'b0;
      w          = 1'b0;
      illegal    = 1'b0;
      readnum    = 3'd0;
      writenum   = 3'd0;

      case (state)
         ST_WAIT: begin
            w = 1'b1;
            if (bus.s) begin
               state_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (is_mov_imm) begin
               state_next = ST_WRITE_IMM;
            end else if (is_mov_reg || is_mvn) begin
               state_next = ST_GET_B;
            end else if (is_alu) begin
               state_next = ST_GET_A;
            end else begin
               illegal    = 1'b1;
               state_next = ST_WAIT;
            end
         end
         ST_WRITE_IMM: begin
            write      = 1'b1;
            vsel       = 1'b1;
            writenum   = rn;
            state_next = ST_WAIT;
         end
         ST_GET_A: begin
            readnum    = rn;
            loada      = 1'b1;
            state_next = ST_GET_B;
         end
         ST_GET_B: begin
            readnum    = rm;
            loadb      = 1'b1;
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            // single-operand forms zero the A input so the ALU passes or inverts B
            asel = is_mov_reg || is_mvn;
            if (is_cmp) begin
               loads      = 1'b1;
               state_next = ST_WAIT;
            end else begin
               loadc      = 1'b1;
               state_next = ST_WRITE_REG;
            end
         end
         ST_WRITE_REG: begin
            write      = 1'b1;
            writenum   = rd;
            state_next = ST_WAIT;
         end
         default: begin
            state_next = ST_WAIT;
         end
      endcase
   end

   assign bus.write    = write;
   assign bus.vsel     = vsel;
   assign bus.loada    = loada;
   assign bus.loadb    = loadb;
   assign bus.asel     = asel;
   assign bus.loadc    = loadc;
   assign bus.loads    = loads;
   assign bus.w        = w;
   assign bus.illegal  = illegal;
   assign bus.readnum  = readnum;
   assign bus.writenum = writenum;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed self-checking bench for cpu_controller
module tb_cpu_controller;

   logic clk;
   logic reset;
   int   tests;
   int   failed;

   cpu_controller_if bus ();

   cpu_controller #(.IR_RESET(16'h0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // strobe order: write vsel loada loadb asel bsel loadc loads illegal
   localparam logic [8:0] SB_NONE = 9'b000000000;
   localparam logic [8:0] SB_WI   = 9'b110000000;
   localparam logic [8:0] SB_GA   = 9'b001000000;
   localparam logic [8:0] SB_GB   = 9'b000100000;
   localparam logic [8:0] SB_EX   = 9'b000000100;
   localparam logic [8:0] SB_EXA  = 9'b000010100;
   localparam logic [8:0] SB_CMP  = 9'b000000010;
   localparam logic [8:0] SB_WR   = 9'b100000000;
   localparam logic [8:0] SB_ILL  = 9'b000000001;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic ctl(input string tag, input logic [8:0] sb, input logic [2:0] rn,
                      input logic [2:0] wn, input logic wexp);
      chk({tag, ".strobes"}, {7'd0, bus.write, bus.vsel, bus.loada, bus.loadb, bus.asel,
                              bus.bsel, bus.loadc, bus.loads, bus.illegal}, {7'd0, sb});
      chk({tag, ".readnum"}, {13'd0, bus.readnum}, {13'd0, rn});
      chk({tag, ".writenum"}, {13'd0, bus.writenum}, {13'd0, wn});
      chk({tag, ".w"}, {15'd0, bus.w}, {15'd0, wexp});
   endtask

   task automatic start(input logic [15:0] instr);
      bus.in   = instr;
      bus.load = 1'b1;
      bus.s    = 1'b1;
      tick();
      bus.load = 1'b0;
      bus.s    = 1'b0;
   endtask

   initial begin
      tests    = 0;
      failed   = 0;
      reset    = 1'b1;
      bus.s    = 1'b0;
      bus.load = 1'b0;
      bus.in   = 16'h0000;
      @(negedge clk);
      tick();
      reset = 1'b0;
      ctl("reset", SB_NONE, 3'd0, 3'd0, 1'b1);
      chk("reset.dp_in", bus.datapath_in, 16'h0000);

      // MOV R0,#7
      start(16'hD007);
      ctl("movi0.decode", SB_NONE, 3'd0, 3'd0, 1'b0);
      tick();
      ctl("movi0.wimm", SB_WI, 3'd0, 3'd0, 1'b0);
      chk("movi0.dp_in", bus.datapath_in, 16'h0007);
      tick();
      ctl("movi0.wait", SB_NONE, 3'd0, 3'd0, 1'b1);

      // MOV R1,#-2
      start(16'hD1FE);
      tick();
      ctl("movi1.wimm", SB_WI, 3'd0, 3'd1, 1'b0);
      chk("movi1.dp_in", bus.datapath_in, 16'hFFFE);
      tick();
      chk("movi1.w", {15'd0, bus.w}, 16'd1);

      // ADD R2,R1,R0,LSL#1
      start(16'hA148);
      ctl("add.decode", SB_NONE, 3'd0, 3'd0, 1'b0);
      tick();
      ctl("add.geta", SB_GA, 3'd1, 3'd0, 1'b0);
      tick();
      ctl("add.getb", SB_GB, 3'd0, 3'd0, 1'b0);
      tick();
      ctl("add.exec", SB_EX, 3'd0, 3'd0, 1'b0);
      chk("add.shift", {14'd0, bus.shift}, 16'd1);
      chk("add.aluop", {14'd0, bus.ALUop}, 16'd0);
      tick();
      ctl("add.wreg", SB_WR, 3'd0, 3'd2, 1'b0);
      tick();
      ctl("add.wait", SB_NONE, 3'd0, 3'd0, 1'b1);

      // CMP R1,R0
      start(16'hA900);
      tick();
      ctl("cmp.geta", SB_GA, 3'd1, 3'd0, 1'b0);
      tick();
      ctl("cmp.getb", SB_GB, 3'd0, 3'd0, 1'b0);
      tick();
      ctl("cmp.exec", SB_CMP, 3'd0, 3'd0, 1'b0);
      chk("cmp.aluop", {14'd0, bus.ALUop}, 16'd1);
      tick();
      ctl("cmp.wait", SB_NONE, 3'd0, 3'd0, 1'b1);

      // MVN R3,R0
      start(16'hB860);
      tick();
      ctl("mvn.getb", SB_GB, 3'd0, 3'd0, 1'b0);
      tick();
      ctl("mvn.exec", SB_EXA, 3'd0, 3'd0, 1'b0);
      chk("mvn.aluop", {14'd0, bus.ALUop}, 16'd3);
      tick();
      ctl("mvn.wreg", SB_WR, 3'd0, 3'd3, 1'b0);
      tick();
      ctl("mvn.wait", SB_NONE, 3'd0, 3'd0, 1'b1);

      // undecodable word
      start(16'h0000);
      ctl("ill.decode", SB_ILL, 3'd0, 3'd0, 1'b0);
      tick();
      ctl("ill.wait", SB_NONE, 3'd0, 3'd0, 1'b1);

      // s held high: one-cycle WAIT visit, IR unchanged without load
      bus.in   = 16'hD245;
      bus.load = 1'b1;
      bus.s    = 1'b1;
      tick();
      bus.load = 1'b0;
      bus.in   = 16'hD7FF;
      tick();
      ctl("hold.wimm1", SB_WI, 3'd0, 3'd2, 1'b0);
      tick();
      ctl("hold.wait", SB_NONE, 3'd0, 3'd0, 1'b1);
      tick();
      ctl("hold.decode", SB_NONE, 3'd0, 3'd0, 1'b0);
      bus.s = 1'b0;
      tick();
      ctl("hold.wimm2", SB_WI, 3'd0, 3'd2, 1'b0);
      chk("hold.dp_in", bus.datapath_in, 16'h0045);
      tick();
      chk("hold.w", {15'd0, bus.w}, 16'd1);

      // load/s ignored mid-instruction, then reset during GET_B
      start(16'hA148);
      bus.load = 1'b1;
      bus.s    = 1'b1;
      bus.in   = 16'hD7FF;
      tick();
      ctl("busy.geta", SB_GA, 3'd1, 3'd0, 1'b0);
      chk("busy.dp_in", bus.datapath_in, 16'h0048);
      tick();
      ctl("busy.getb", SB_GB, 3'd0, 3'd0, 1'b0);
      bus.load = 1'b0;
      bus.s    = 1'b0;
      reset    = 1'b1;
      tick();
      reset = 1'b0;
      ctl("rst.after", SB_NONE, 3'd0, 3'd0, 1'b1);
      chk("rst.ir", bus.datapath_in, 16'h0000);
      tick();
      ctl("rst.idle", SB_NONE, 3'd0, 3'd0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
